zbt_pixel_writer: RTL and testbench

ZBT_PIXEL_WRITER -- requirements
Module: zbt_pixel_writer

---
 rtl/zbt_pixel_writer_pkg.sv | 21 ++
 rtl/zbt_pixel_writer_if.sv | 27 ++
 rtl/zbt_wr_fifo.sv | 49 ++++
 rtl/zbt_pixel_writer.sv | 135 +++++++++++++
 tb/tb_zbt_pixel_writer.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/zbt_pixel_writer_pkg.sv
// Shared widths, the write-FIFO entry type and the pixel reduction helper.
package zbt_pixel_writer_pkg;

  localparam int ZBT_AW     = 19;
  localparam int ZBT_DW     = 36;
  localparam int PIX_W      = 18;
  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_PW    = 2;
  localparam int FIFO_CW    = 3;

  typedef struct packed {
    logic [ZBT_AW-1:0] addr;
    logic [ZBT_DW-1:0] data;
  } wr_entry_t;

  // Keep the top six bits of each colour channel.
  function automatic logic [PIX_W-1:0] pix_reduce(input logic [23:0] rgb);
    return {rgb[23:18], rgb[15:10], rgb[7:2]};
  endfunction

endpackage

// File: rtl/zbt_pixel_writer_if.sv
// Pixel stream in, ZBT write port out. Latency n/a (wires only).
// No backpressure on pixels; the ZBT side is paced by wr_grant.
interface zbt_pixel_writer_if;

  logic                                    pix_valid;
  logic [23:0]                             pix_rgb;
  logic [10:0]                             pix_hcount;
  logic [9:0]                              pix_vcount;
  logic                                    frame_start;
  logic                                    wr_grant;
  logic                                    zbt_we;
  logic [zbt_pixel_writer_pkg::ZBT_AW-1:0] zbt_addr;
  logic [zbt_pixel_writer_pkg::ZBT_DW-1:0] zbt_wdata;
  logic                                    overflow;
  logic                                    orphan;

  modport master (
    output pix_valid, pix_rgb, pix_hcount, pix_vcount, frame_start, wr_grant,
    input  zbt_we, zbt_addr, zbt_wdata, overflow, orphan
  );

  modport slave (
    input  pix_valid, pix_rgb, pix_hcount, pix_vcount, frame_start, wr_grant,
    output zbt_we, zbt_addr, zbt_wdata, overflow, orphan
  );

endinterface

// File: rtl/zbt_wr_fifo.sv
// 4-entry synchronous write FIFO; head is visible combinationally on pop_dat.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module zbt_wr_fifo
  import zbt_pixel_writer_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  wr_entry_t          push_dat,
  input  logic               pop,
  output wr_entry_t          pop_dat,
  output logic               full,
  output logic               empty,
  output logic [FIFO_CW-1:0] count
);

  wr_entry_t          mem [FIFO_DEPTH];
  logic [FIFO_PW-1:0] wr_ptr;
  logic [FIFO_PW-1:0] rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FIFO_CW'(FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/zbt_pixel_writer.sv
// Pairs even/odd pixels into 36-bit ZBT words; 2 cycles from completing pixel to zbt_we.
// Words queue in a 4-deep FIFO drained on wr_grant; a push into a full FIFO is dropped and flagged.
module zbt_pixel_writer
  import zbt_pixel_writer_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  zbt_pixel_writer_if.slave bus
);

  logic               hold_valid;
  logic [9:0]         hold_v;
  logic [9:0]         hold_h;
  logic [PIX_W-1:0]   hold_pix;

  logic               stg_vld;
  wr_entry_t          stg_dat;

  logic [PIX_W-1:0]   pix18;
  logic               hold_live;
  logic               is_even;
  logic               key_match;
  logic               push_new;
  wr_entry_t          push_entry;
  logic               orphan_set;

  wr_entry_t          head;
  logic               fifo_full;
  logic               fifo_empty;
  logic [FIFO_CW-1:0] fifo_count;
  logic               pop;

  logic               we_q;
  logic [ZBT_AW-1:0]  addr_q;
  logic [ZBT_DW-1:0]  wdata_q;
  logic               overflow_q;
  logic               orphan_q;

  // frame_start takes effect before the pixel of the same cycle is looked at.
  always_comb begin
    pix18      = pix_reduce(bus.pix_rgb);
    hold_live  = hold_valid && !bus.frame_start;
    is_even    = !bus.pix_hcount[0];
    key_match  = hold_live && (hold_v == bus.pix_vcount) && (hold_h == bus.pix_hcount[10:1]);
    push_new   = 1'b0;
    push_entry = '0;
    orphan_set = 1'b0;
    if (bus.pix_valid) begin
      if (is_even) begin
        if (hold_live) begin
          push_new        = 1'b1;
          push_entry.addr = {hold_v, hold_h[8:0]};
          push_entry.data = {{PIX_W{1'b0}}, hold_pix};
        end
      end else if (key_match) begin
        push_new        = 1'b1;
        push_entry.addr = {hold_v, hold_h[8:0]};
        push_entry.data = {pix18, hold_pix};
      end else begin
        orphan_set = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_valid <= 1'b0;
      hold_v     <= '0;
      hold_h     <= '0;
      hold_pix   <= '0;
    end else begin
      if (bus.frame_start) hold_valid <= 1'b0;
      if (bus.pix_valid) begin
        if (is_even) begin
          hold_valid <= 1'b1;
          hold_v     <= bus.pix_vcount;
          hold_h     <= bus.pix_hcount[10:1];
          hold_pix   <= pix18;
        end else if (key_match) begin
          hold_valid <= 1'b0;
        end
      end
    end
  end

  // One register stage ahead of the FIFO sets the 2-cycle write latency.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stg_vld <= 1'b0;
      stg_dat <= '0;
    end else begin
      stg_vld <= push_new;
      stg_dat <= push_entry;
    end
  end

  assign pop = bus.wr_grant && !fifo_empty;

  zbt_wr_fifo u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (stg_vld),
    .push_dat (stg_dat),
    .pop      (pop),
    .pop_dat  (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      overflow_q <= 1'b0;
      orphan_q   <= 1'b0;
    end else begin
      we_q <= pop;
      if (pop) begin
        addr_q  <= head.addr;
        wdata_q <= head.data;
      end
      overflow_q <= (overflow_q && !bus.frame_start) || (stg_vld && fifo_full && !pop);
      orphan_q   <= (orphan_q && !bus.frame_start) || orphan_set;
    end
  end

  assign bus.zbt_we    = we_q;
  assign bus.zbt_addr  = addr_q;
  assign bus.zbt_wdata = wdata_q;
  assign bus.overflow  = overflow_q;
  assign bus.orphan    = orphan_q;

endmodule

// File: tb/tb_zbt_pixel_writer.sv
// Directed bench for zbt_pixel_writer: pairing, orphans, FIFO full/overflow, reset abort.
module tb_zbt_pixel_writer;

  logic clock;
  logic reset;

  zbt_pixel_writer_if bus ();

  zbt_pixel_writer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  logic [18:0] wa [64];
  logic [35:0] wd [64];

  // Writes are captured 2 units after the rising edge, away from the bench's negedge checks.
  always @(posedge clock) begin
    #2;
    if (bus.zbt_we === 1'b1) begin
      if (wr_cnt < 64) begin
        wa[wr_cnt] = bus.zbt_addr;
        wd[wr_cnt] = bus.zbt_wdata;
      end
      wr_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pix(input int h, input int v, input logic [23:0] rgb, input logic fs);
    bus.pix_valid   = 1'b1;
    bus.pix_hcount  = 11'(h);
    bus.pix_vcount  = 10'(v);
    bus.pix_rgb     = rgb;
    bus.frame_start = fs;
    @(negedge clock);
    bus.pix_valid   = 1'b0;
    bus.frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_writes(input int target, input int budget);
    int k;
    k = 0;
    while (wr_cnt < target && k < budget) begin
      @(negedge clock);
      k++;
    end
    if (wr_cnt < target) check("write_timeout", 64'(wr_cnt), 64'(target));
  endtask

  task automatic pulse_frame_start();
    bus.frame_start = 1'b1;
    @(negedge clock);
    bus.frame_start = 1'b0;
  endtask

  int base;
  int cnt_rst;

  initial begin
    reset           = 1'b1;
    bus.pix_valid   = 1'b0;
    bus.pix_rgb     = '0;
    bus.pix_hcount  = '0;
    bus.pix_vcount  = '0;
    bus.frame_start = 1'b0;
    bus.wr_grant    = 1'b0;
    @(negedge clock);
    check("rst_we",       64'(bus.zbt_we),         64'h0);
    check("rst_addr",     64'(bus.zbt_addr),       64'h0);
    check("rst_wdata",    64'(bus.zbt_wdata),      64'h0);
    check("rst_overflow", 64'(bus.overflow),       64'h0);
    check("rst_orphan",   64'(bus.orphan),         64'h0);
    check("rst_hold",     64'(dut.hold_valid),     64'h0);
    check("rst_count",    64'(dut.u_fifo.count),   64'h0);
    @(negedge clock);
    reset = 1'b0;
    idle(2);

    // Basic pair and 2-cycle latency, then outputs hold once zbt_we drops.
    bus.wr_grant = 1'b1;
    pix(4, 2, 24'hFFFFFF, 1'b0);
    pix(5, 2, 24'h000000, 1'b0);
    check("lat_c0_we", 64'(bus.zbt_we), 64'h0);
    @(negedge clock);
    check("lat_c1_we", 64'(bus.zbt_we), 64'h0);
    @(negedge clock);
    check("lat_c2_we",    64'(bus.zbt_we),    64'h1);
    check("lat_c2_addr",  64'(bus.zbt_addr),  64'h00402);
    check("lat_c2_wdata", 64'(bus.zbt_wdata), 64'h00003FFFF);
    @(negedge clock);
    check("lat_c3_we",         64'(bus.zbt_we),    64'h0);
    check("hold_last_addr",    64'(bus.zbt_addr),  64'h00402);
    check("hold_last_wdata",   64'(bus.zbt_wdata), 64'h00003FFFF);

    // Odd pixel with nothing held.
    base = wr_cnt;
    pix(7, 2, 24'h5A5A5A, 1'b0);
    idle(4);
    check("orphan_no_write", 64'(wr_cnt - base), 64'h0);
    check("orphan_flag",     64'(bus.orphan),    64'h1);
    pulse_frame_start();
    check("fs_clears_orphan", 64'(bus.orphan), 64'h0);

    // Even then even: old hold flushed with empty upper half, newer one stays held.
    base = wr_cnt;
    pix(8, 3, 24'h123456, 1'b0);
    pix(10, 3, 24'hABCDEF, 1'b0);
    idle(3);
    check("ee_writes", 64'(wr_cnt - base), 64'h1);
    check("ee_addr",   64'(wa[base]),      64'h00604);
    check("ee_wdata",  64'(wd[base]),      64'h000004355);
    check("ee_hold",   64'(dut.hold_valid), 64'h1);
    check("ee_hold_h", 64'(dut.hold_h),     64'h5);
    pix(11, 3, 24'hFFFFFF, 1'b0);
    idle(3);
    check("ee_pair_writes", 64'(wr_cnt - base), 64'h2);
    check("ee_pair_addr",   64'(wa[base+1]),    64'h00605);
    check("ee_pair_wdata",  64'(wd[base+1]),    64'hFFFFEACFB);

    // frame_start together with an even pixel: old hold discarded, new one kept.
    base = wr_cnt;
    pix(20, 1, 24'h111111, 1'b0);
    pix(30, 1, 24'h222222, 1'b1);
    pix(31, 1, 24'h333333, 1'b0);
    idle(4);
    check("fs_pix_writes", 64'(wr_cnt - base), 64'h1);
    check("fs_pix_addr",   64'(wa[base]),      64'h0020F);
    check("fs_pix_wdata",  64'(wd[base]),      64'h30C308208);

    // Five pairs with no grant: four queued, fifth dropped.
    bus.wr_grant = 1'b0;
    base = wr_cnt;
    for (int k = 0; k < 5; k++) begin
      pix(2*k,   5, 24'hFFFFFF, 1'b0);
      pix(2*k+1, 5, 24'h000000, 1'b0);
    end
    idle(3);
    check("ovf_no_write", 64'(wr_cnt - base),     64'h0);
    check("ovf_count",    64'(dut.u_fifo.count),  64'h4);
    check("ovf_flag",     64'(bus.overflow),      64'h1);
    bus.wr_grant = 1'b1;
    wait_writes(base + 4, 20);
    idle(3);
    check("ovf_drain_writes", 64'(wr_cnt - base), 64'h4);
    check("ovf_drain_first",  64'(wa[base]),      64'h00A00);
    check("ovf_drain_last",   64'(wa[base+3]),    64'h00A03);
    pulse_frame_start();
    check("fs_clears_overflow", 64'(bus.overflow), 64'h0);

    // Full FIFO, push and pop land on the same edge.
    bus.wr_grant = 1'b0;
    base = wr_cnt;
    for (int k = 0; k < 4; k++) begin
      pix(2*k,   6, 24'hFFFFFF, 1'b0);
      pix(2*k+1, 6, 24'h000000, 1'b0);
    end
    idle(3);
    check("full_count", 64'(dut.u_fifo.count), 64'h4);
    pix(8, 6, 24'hFFFFFF, 1'b0);
    pix(9, 6, 24'h000000, 1'b0);
    bus.wr_grant = 1'b1;
    @(negedge clock);
    check("pp_overflow", 64'(bus.overflow),     64'h0);
    check("pp_count",    64'(dut.u_fifo.count), 64'h4);
    check("pp_we",       64'(bus.zbt_we),       64'h1);
    check("pp_addr",     64'(bus.zbt_addr),     64'h00C00);
    bus.wr_grant = 1'b0;
    idle(2);
    check("pp_count_held", 64'(dut.u_fifo.count), 64'h4);
    check("pp_overflow2",  64'(bus.overflow),     64'h0);
    bus.wr_grant = 1'b1;
    wait_writes(base + 5, 20);
    idle(3);
    check("pp_total_writes", 64'(wr_cnt - base), 64'h5);
    check("pp_last_addr",    64'(wa[base+4]),    64'h00C04);

    // Reset during a write aborts it and empties the FIFO.
    bus.wr_grant = 1'b0;
    base = wr_cnt;
    for (int k = 0; k < 3; k++) begin
      pix(2*k,   7, 24'hFFFFFF, 1'b0);
      pix(2*k+1, 7, 24'h000000, 1'b0);
    end
    idle(3);
    check("rw_count", 64'(dut.u_fifo.count), 64'h3);
    bus.wr_grant = 1'b1;
    @(negedge clock);
    check("rw_we_before", 64'(bus.zbt_we), 64'h1);
    #2;
    reset = 1'b1;
    #1;
    check("rw_we_drop",  64'(bus.zbt_we),       64'h0);
    check("rw_count0",   64'(dut.u_fifo.count), 64'h0);
    check("rw_addr0",    64'(bus.zbt_addr),     64'h0);
    check("rw_wdata0",   64'(bus.zbt_wdata),    64'h0);
    idle(2);
    reset = 1'b0;
    cnt_rst = wr_cnt;
    check("rw_writes_before", 64'(cnt_rst - base), 64'h1);
    idle(8);
    check("rw_no_writes_after", 64'(wr_cnt - cnt_rst), 64'h0);
    pix(0, 8, 24'hFFFFFF, 1'b0);
    pix(1, 8, 24'h000000, 1'b0);
    idle(4);
    check("rw_new_writes", 64'(wr_cnt - cnt_rst), 64'h1);
    check("rw_new_addr",   64'(wa[cnt_rst]),      64'h01000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
